// File: rtl/riscv_wb_pkg.sv
// ============================================================================
// Module   : riscv_wb_pkg
// Brief    : Shared types and default sizing for the write-back arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_wb_pkg;

  localparam int C_DEF_ADDR_WIDTH     = 6;
  localparam int C_DEF_DATA_WIDTH     = 32;
  localparam int C_DEF_LSU_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [C_DEF_ADDR_WIDTH-1:0] waddr;
    logic [C_DEF_DATA_WIDTH-1:0] wdata;
  } wb_req_t;

  // Which port B source wins when both request.
  typedef enum logic [0:0] {
    RR_MUL = 1'b0,
    RR_LSU = 1'b1
  } rr_pri_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_wb_fifo.sv
// ============================================================================
// Module   : riscv_wb_fifo
// Brief    : LSU result buffer, valid/ready push and pop strobe, registered
//            occupancy so a pushed entry is visible one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_wb_fifo
  import riscv_wb_pkg::*;
#(
  parameter int DEPTH = C_DEF_LSU_FIFO_DEPTH,
  parameter int WIDTH = C_DEF_ADDR_WIDTH + C_DEF_DATA_WIDTH
) (
  input  logic             clk_int,
  input  logic             rst_n,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_head_valid,
  output logic [WIDTH-1:0] o_head_data
);

  localparam int              PTR_W  = ptr_width(DEPTH);
  localparam int              CNT_W  = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_LAST) ? '0 : p + 1'b1;
  endfunction

  assign o_push_ready = (r_count != C_FULL);
  assign o_head_valid = (r_count != '0);
  assign o_head_data  = r_mem[r_rptr];
  assign w_push       = i_push_valid && o_push_ready;
  assign w_pop        = i_pop && o_head_valid;

  always_ff @(posedge clk_int) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/riscv_wb_arbiter.sv
// ============================================================================
// Module   : riscv_wb_arbiter
// Brief    : Register-file write-back arbiter: ALU on port A, round-robin of
//            MUL / buffered LSU results on port B. Optional pending-write
//            scoreboard enabled by macro RISCV_WB_SCOREBOARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_wb_arbiter
  import riscv_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = C_DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = C_DEF_DATA_WIDTH,
  parameter int LSU_FIFO_DEPTH = C_DEF_LSU_FIFO_DEPTH
) (
  input  logic                     clk_int,
  input  logic                     rst_n,
  input  logic                     alu_we_i,
  input  logic [ADDR_WIDTH-1:0]    alu_waddr_i,
  input  logic [DATA_WIDTH-1:0]    alu_wdata_i,
  input  logic                     mul_valid_i,
  input  logic [ADDR_WIDTH-1:0]    mul_waddr_i,
  input  logic [DATA_WIDTH-1:0]    mul_wdata_i,
  output logic                     mul_ready_o,
  input  logic                     lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0]    lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0]    lsu_wdata_i,
  output logic                     lsu_ready_o,
  input  logic                     issue_i,
  input  logic [ADDR_WIDTH-1:0]    issue_waddr_i,
  output logic [2**ADDR_WIDTH-1:0] busy_o,
  output logic                     we_a_o,
  output logic [ADDR_WIDTH-1:0]    waddr_a_o,
  output logic [DATA_WIDTH-1:0]    wdata_a_o,
  output logic                     we_b_o,
  output logic [ADDR_WIDTH-1:0]    waddr_b_o,
  output logic [DATA_WIDTH-1:0]    wdata_b_o,
  output logic                     collision_o
);

  localparam int C_REQ_W = ADDR_WIDTH + DATA_WIDTH;

  logic                  r_we_a;
  logic [ADDR_WIDTH-1:0] r_waddr_a;
  logic [DATA_WIDTH-1:0] r_wdata_a;
  logic                  r_we_b;
  logic [ADDR_WIDTH-1:0] r_waddr_b;
  logic [DATA_WIDTH-1:0] r_wdata_b;
  logic                  r_collision;
  rr_pri_t               r_rr;

  logic                  w_head_valid;
  logic [C_REQ_W-1:0]    w_head_data;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_wdata;
  logic                  w_both;
  logic                  w_any;
  logic                  w_pick_mul;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic                  w_collide;
  logic                  w_grant;
  logic                  w_grant_mul;
  logic                  w_grant_lsu;

  riscv_wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH),
    .WIDTH (C_REQ_W)
  ) u_lsu_fifo (
    .clk_int      (clk_int),
    .rst_n        (rst_n),
    .i_push_valid (lsu_valid_i),
    .o_push_ready (lsu_ready_o),
    .i_push_data  ({lsu_waddr_i, lsu_wdata_i}),
    .i_pop        (w_grant_lsu),
    .o_head_valid (w_head_valid),
    .o_head_data  (w_head_data)
  );

  assign w_head_addr  = w_head_data[C_REQ_W-1:DATA_WIDTH];
  assign w_head_wdata = w_head_data[DATA_WIDTH-1:0];

  assign w_both     = mul_valid_i && w_head_valid;
  assign w_any      = mul_valid_i || w_head_valid;
  assign w_pick_mul = w_both ? (r_rr == RR_MUL) : mul_valid_i;
  assign w_win_addr = w_pick_mul ? mul_waddr_i : w_head_addr;
  assign w_win_data = w_pick_mul ? mul_wdata_i : w_head_wdata;

  // Defer B when the ALU claims the same nonzero register this cycle, so the
  // two write ports never target one register together.
  assign w_collide   = w_any && alu_we_i && (alu_waddr_i != '0) &&
                       (w_win_addr == alu_waddr_i);
  assign w_grant     = rst_n && w_any && !w_collide;
  assign w_grant_mul = w_grant && w_pick_mul;
  assign w_grant_lsu = w_grant && !w_pick_mul;
  assign mul_ready_o = w_grant_mul;

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      r_we_a      <= 1'b0;
      r_waddr_a   <= '0;
      r_wdata_a   <= '0;
      r_we_b      <= 1'b0;
      r_waddr_b   <= '0;
      r_wdata_b   <= '0;
      r_collision <= 1'b0;
      r_rr        <= RR_MUL;
    end else begin
      r_we_a      <= alu_we_i && (alu_waddr_i != '0);
      r_waddr_a   <= alu_waddr_i;
      r_wdata_a   <= alu_wdata_i;
      r_we_b      <= w_grant && (w_win_addr != '0);
      r_waddr_b   <= w_grant ? w_win_addr : '0;
      r_wdata_b   <= w_grant ? w_win_data : '0;
      r_collision <= w_collide;
      if (w_grant && w_both) begin
        r_rr <= w_pick_mul ? RR_LSU : RR_MUL;
      end
    end
  end

  assign we_a_o      = r_we_a;
  assign waddr_a_o   = r_waddr_a;
  assign wdata_a_o   = r_wdata_a;
  assign we_b_o      = r_we_b;
  assign waddr_b_o   = r_waddr_b;
  assign wdata_b_o   = r_wdata_b;
  assign collision_o = r_collision;

`ifdef RISCV_WB_SCOREBOARD_EN
  localparam int C_NREG = 2**ADDR_WIDTH;

  logic [C_NREG-1:0] r_busy;
  logic [C_NREG-1:0] w_clr;
  logic [C_NREG-1:0] w_set;

  // The clear is visible in the same cycle the port B write is driven; a
  // reservation arriving in that cycle still wins on the next edge.
  assign w_clr  = r_we_b ? (C_NREG'(1) << r_waddr_b) : '0;
  assign w_set  = (issue_i && (issue_waddr_i != '0)) ? (C_NREG'(1) << issue_waddr_i) : '0;
  assign busy_o = r_busy & ~w_clr;

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end
`else
  logic w_unused_issue;
  assign w_unused_issue = ^{issue_i, issue_waddr_i};
  assign busy_o         = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_riscv_wb_arbiter.sv
// Testbench for riscv_wb_arbiter: vector table for port A, directed corner
// sequences, then randomized traffic against a queue-based reference model.
`default_nettype none

module tb_riscv_wb_arbiter;
  import riscv_wb_pkg::*;

  localparam int DEPTH = 2;

  logic        clk_int = 1'b0;
  logic        rst_n;
  logic        alu_we;
  logic [5:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        mul_valid;
  logic [5:0]  mul_waddr;
  logic [31:0] mul_wdata;
  logic        mul_ready_o;
  logic        lsu_valid;
  logic [5:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        lsu_ready_o;
  logic        issue;
  logic [5:0]  issue_waddr;
  logic [63:0] busy_o;
  logic        we_a_o;
  logic [5:0]  waddr_a_o;
  logic [31:0] wdata_a_o;
  logic        we_b_o;
  logic [5:0]  waddr_b_o;
  logic [31:0] wdata_b_o;
  logic        collision_o;

  riscv_wb_arbiter dut (
    .clk_int       (clk_int),
    .rst_n         (rst_n),
    .alu_we_i      (alu_we),
    .alu_waddr_i   (alu_waddr),
    .alu_wdata_i   (alu_wdata),
    .mul_valid_i   (mul_valid),
    .mul_waddr_i   (mul_waddr),
    .mul_wdata_i   (mul_wdata),
    .mul_ready_o   (mul_ready_o),
    .lsu_valid_i   (lsu_valid),
    .lsu_waddr_i   (lsu_waddr),
    .lsu_wdata_i   (lsu_wdata),
    .lsu_ready_o   (lsu_ready_o),
    .issue_i       (issue),
    .issue_waddr_i (issue_waddr),
    .busy_o        (busy_o),
    .we_a_o        (we_a_o),
    .waddr_a_o     (waddr_a_o),
    .wdata_a_o     (wdata_a_o),
    .we_b_o        (we_b_o),
    .waddr_b_o     (waddr_b_o),
    .wdata_b_o     (wdata_b_o),
    .collision_o   (collision_o)
  );

  always #5 clk_int = ~clk_int;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_int);
    #1;
  endtask

  task automatic idle_inputs();
    alu_we = 1'b0; alu_waddr = '0; alu_wdata = '0;
    mul_valid = 1'b0; mul_waddr = '0; mul_wdata = '0;
    lsu_valid = 1'b0; lsu_waddr = '0; lsu_wdata = '0;
    issue = 1'b0; issue_waddr = '0;
  endtask

  // ---------------- reference model ----------------
  wb_req_t     mq[$];
  bit          m_lsu_turn;
  logic        m_we_a, m_we_b, m_coll;
  logic [5:0]  m_waddr_a, m_waddr_b;
  logic [31:0] m_wdata_a, m_wdata_b;
  logic [63:0] m_busy;
  logic        n_we_a, n_we_b, n_coll;
  logic [5:0]  n_waddr_a, n_waddr_b;
  logic [31:0] n_wdata_a, n_wdata_b;
  logic [63:0] n_busy, e_busy;
  logic        e_mul_ready, e_lsu_ready;
  bit          n_pop, n_push, n_turn_upd, n_turn;
  wb_req_t     n_item;

  task automatic model_init();
    mq.delete();
    m_lsu_turn = 0;
    m_we_a = 0; m_waddr_a = '0; m_wdata_a = '0;
    m_we_b = 0; m_waddr_b = '0; m_wdata_b = '0;
    m_coll = 0; m_busy = '0;
  endtask

  task automatic model_eval();
    bit      head_v, mul_first, any, coll, grant;
    wb_req_t cand;
    head_v      = (mq.size() != 0);
    e_lsu_ready = (mq.size() < DEPTH);
    any         = mul_valid || head_v;
    mul_first   = mul_valid && !(head_v && m_lsu_turn);
    if (mul_first) begin
      cand.waddr = mul_waddr; cand.wdata = mul_wdata;
    end else if (head_v) begin
      cand = mq[0];
    end else begin
      cand.waddr = '0; cand.wdata = '0;
    end
    coll  = any && alu_we && (alu_waddr != 0) && (cand.waddr == alu_waddr);
    grant = any && !coll;
    e_mul_ready = grant && mul_first;
    n_we_a    = alu_we && (alu_waddr != 0);
    n_waddr_a = alu_waddr;
    n_wdata_a = alu_wdata;
    n_we_b    = grant && (cand.waddr != 0);
    n_waddr_b = grant ? cand.waddr : 6'd0;
    n_wdata_b = grant ? cand.wdata : 32'd0;
    n_coll    = coll;
    n_pop     = grant && !mul_first;
    n_push    = lsu_valid && e_lsu_ready;
    n_item.waddr = lsu_waddr; n_item.wdata = lsu_wdata;
    n_turn_upd = grant && mul_valid && head_v;
    n_turn     = mul_first;
`ifdef RISCV_WB_SCOREBOARD_EN
    e_busy = m_busy & ~(m_we_b ? (64'd1 << m_waddr_b) : 64'd0);
    n_busy = e_busy | ((issue && issue_waddr != 0) ? (64'd1 << issue_waddr) : 64'd0);
`else
    e_busy = '0;
    n_busy = '0;
`endif
  endtask

  task automatic model_commit();
    m_we_a = n_we_a; m_waddr_a = n_waddr_a; m_wdata_a = n_wdata_a;
    m_we_b = n_we_b; m_waddr_b = n_waddr_b; m_wdata_b = n_wdata_b;
    m_coll = n_coll; m_busy = n_busy;
    if (n_pop) void'(mq.pop_front());
    if (n_push) mq.push_back(n_item);
    if (n_turn_upd) m_lsu_turn = n_turn;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk_int);
    #1;
    rst_n = 1'b1;
    model_init();
  endtask

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        exp_we;
    logic [5:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs[5];
  logic [5:0]  rr_exp[4];
  logic [5:0]  mul_next, lsu_next;
  logic        mr, lr, mul_done;

  initial begin
    vecs[0] = '{1'b1, 6'd5,  32'hDEADBEEF, 1'b1, 6'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 6'd0,  32'h12345678, 1'b0, 6'd0,  32'h12345678};
    vecs[2] = '{1'b0, 6'd9,  32'h00000000, 1'b0, 6'd9,  32'h00000000};
    vecs[3] = '{1'b1, 6'd63, 32'hFFFFFFFF, 1'b1, 6'd63, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, 6'd1,  32'hA5A5A5A5, 1'b1, 6'd1,  32'hA5A5A5A5};
    rr_exp[0] = 6'd40; rr_exp[1] = 6'd20; rr_exp[2] = 6'd41; rr_exp[3] = 6'd21;

    // Reset values, with a MUL request present to prove ready stays low.
    idle_inputs();
    rst_n = 1'b0;
    mul_valid = 1'b1; mul_waddr = 6'd3;
    #1;
    chk("reset_outs", 128'({we_a_o, we_b_o, collision_o, mul_ready_o, lsu_ready_o}), 128'(5'b00001));
    chk("reset_data", 128'({waddr_a_o, wdata_a_o, waddr_b_o, wdata_b_o}), 128'(0));
    chk("reset_busy", 128'(busy_o), 128'(0));
    do_reset();

    // Port A vector table
    for (int i = 0; i < 5; i++) begin
      alu_we = vecs[i].we; alu_waddr = vecs[i].addr; alu_wdata = vecs[i].data;
      tick();
      chk("portA_vec", 128'({we_a_o, waddr_a_o, wdata_a_o, we_b_o}),
          128'({vecs[i].exp_we, vecs[i].exp_addr, vecs[i].exp_data, 1'b0}));
    end
    alu_we = 1'b0;

    // MUL 7 and LSU 9, 10 fill the FIFO; third push held off while full
    do_reset();
    lsu_valid = 1'b1; lsu_waddr = 6'd9; lsu_wdata = 32'h99;
    #1 chk("order_rdy0", 128'(lsu_ready_o), 128'(1));
    tick();
    lsu_waddr = 6'd10; lsu_wdata = 32'hAA;
    mul_valid = 1'b1; mul_waddr = 6'd7; mul_wdata = 32'h77;
    #1 chk("order_mulrdy", 128'(mul_ready_o), 128'(1));
    tick();
    chk("order_b0", 128'({we_b_o, waddr_b_o, wdata_b_o}), 128'({1'b1, 6'd7, 32'h77}));
    mul_valid = 1'b0;
    lsu_waddr = 6'd11; lsu_wdata = 32'hBB;
    chk("order_full", 128'(lsu_ready_o), 128'(0));
    tick();
    chk("order_b1", 128'({we_b_o, waddr_b_o, wdata_b_o}), 128'({1'b1, 6'd9, 32'h99}));
    lsu_valid = 1'b0;
    tick();
    chk("order_b2", 128'({we_b_o, waddr_b_o, wdata_b_o}), 128'({1'b1, 6'd10, 32'hAA}));
    tick();
    chk("order_noextra", 128'(we_b_o), 128'(0));

    // Round-robin alternation with both sources requesting
    do_reset();
    lsu_valid = 1'b1; lsu_waddr = 6'd20; lsu_wdata = 32'h20;
    tick();
    mul_valid = 1'b1; mul_next = 6'd40; lsu_next = 6'd21;
    for (int i = 0; i < 4; i++) begin
      mul_waddr = mul_next; mul_wdata = {26'h0, mul_next};
      lsu_waddr = lsu_next; lsu_wdata = {26'h0, lsu_next};
      #1;
      mr = mul_ready_o; lr = lsu_ready_o;
      tick();
      chk("rr_alt", 128'({we_b_o, waddr_b_o}), 128'({1'b1, rr_exp[i]}));
      if (mr) mul_next = mul_next + 6'd1;
      if (lr) lsu_next = lsu_next + 6'd1;
    end

    // ALU / MUL collision on address 12
    do_reset();
    alu_we = 1'b1; alu_waddr = 6'd12; alu_wdata = 32'hA;
    mul_valid = 1'b1; mul_waddr = 6'd12; mul_wdata = 32'hB;
    #1 chk("coll_noready", 128'(mul_ready_o), 128'(0));
    tick();
    chk("coll_cycle1", 128'({we_a_o, waddr_a_o, collision_o, we_b_o}), 128'({1'b1, 6'd12, 1'b1, 1'b0}));
    alu_we = 1'b0;
    #1 chk("coll_retry_ready", 128'(mul_ready_o), 128'(1));
    tick();
    mul_valid = 1'b0;
    chk("coll_cycle2", 128'({we_b_o, waddr_b_o, wdata_b_o, collision_o}), 128'({1'b1, 6'd12, 32'hB, 1'b0}));

`ifdef RISCV_WB_SCOREBOARD_EN
    do_reset();
    issue = 1'b1; issue_waddr = 6'd3;
    tick();
    chk("sb_set3", 128'(busy_o[3]), 128'(1));
    issue_waddr = 6'd0;
    tick();
    issue = 1'b0;
    chk("sb_zero", 128'(busy_o[0]), 128'(0));
    mul_valid = 1'b1; mul_waddr = 6'd3; mul_wdata = 32'h3;
    tick();
    mul_valid = 1'b0;
    chk("sb_clear", 128'({we_b_o, waddr_b_o, busy_o[3]}), 128'({1'b1, 6'd3, 1'b0}));
`else
    do_reset();
    issue = 1'b1; issue_waddr = 6'd3;
    tick();
    issue = 1'b0;
    chk("sb_off", 128'(busy_o), 128'(0));
`endif

    // Reset while the FIFO holds two deferred entries
    do_reset();
    alu_we = 1'b1; alu_waddr = 6'd50;
    mul_valid = 1'b1; mul_waddr = 6'd50;
    lsu_valid = 1'b1; lsu_waddr = 6'd30;
    tick();
    lsu_waddr = 6'd31;
    tick();
    chk("rst_fifo_full", 128'(lsu_ready_o), 128'(0));
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 128'({lsu_ready_o, we_b_o, busy_o}), 128'({1'b1, 1'b0, 64'd0}));
    repeat (2) @(posedge clk_int);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_b", 128'({we_b_o, lsu_ready_o, busy_o}), 128'({1'b0, 1'b1, 64'd0}));
    end

    // Randomized traffic against the reference model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      alu_we    = 1'($urandom_range(0, 1));
      alu_waddr = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      alu_wdata = $urandom;
      if (!mul_valid && ($urandom_range(0, 1) == 1)) begin
        mul_valid = 1'b1;
        mul_waddr = 6'($urandom_range(0, 7));
        mul_wdata = $urandom;
      end
      lsu_valid   = ($urandom_range(0, 2) != 0);
      lsu_waddr   = 6'($urandom_range(0, 7));
      lsu_wdata   = $urandom;
      issue       = ($urandom_range(0, 3) == 0);
      issue_waddr = 6'($urandom_range(0, 7));
      #1;
      model_eval();
      chk("rand_comb", 128'({mul_ready_o, lsu_ready_o, busy_o}), 128'({e_mul_ready, e_lsu_ready, e_busy}));
      mul_done = e_mul_ready;
      tick();
      model_commit();
      chk("rand_regs", 128'({we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, wdata_b_o, collision_o}),
          128'({m_we_a, m_waddr_a, m_wdata_a, m_we_b, m_waddr_b, m_wdata_b, m_coll}));
      if (mul_done) mul_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/riscv_wb_arbiter.md
RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, register address width (bit 5 selects the FP bank).
REQ-002 Parameter DATA_WIDTH, default 32, write data width.
REQ-003 Parameter LSU_FIFO_DEPTH, default 2, LSU result buffer entries.
REQ-004 Reset is rst_n, asynchronous, active-low; the clock is clk_int.
REQ-005 Ports:
- clk_int  in  1  clock.
- rst_n  in  1  async reset.
- alu_we_i / alu_waddr_i / alu_wdata_i  in  1 / ADDR_WIDTH / DATA_WIDTH  ALU result, always accepted.
- mul_valid_i / mul_waddr_i / mul_wdata_i  in  1 / ADDR_WIDTH / DATA_WIDTH  multiplier result.
- mul_ready_o  out  1  multiplier result consumed this cycle.
- lsu_valid_i / lsu_waddr_i / lsu_wdata_i  in  1 / ADDR_WIDTH / DATA_WIDTH  load result.
- lsu_ready_o  out  1  LSU FIFO not full.
- issue_i / issue_waddr_i  in  1 / ADDR_WIDTH  long-latency op issued, destination reserved.
- busy_o  out  2**ADDR_WIDTH  pending-write flags.
- we_a_o / waddr_a_o / wdata_a_o  out  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port A.
- we_b_o / waddr_b_o / wdata_b_o  out  1 / ADDR_WIDTH / DATA_WIDTH  register-file write port B.
- collision_o  out  1  A and B candidates targeted the same address; B deferred.

Function
REQ-006 Port A SHALL register the ALU result: outputs in cycle N+1 equal alu_* inputs of cycle N.
REQ-007 Any write to address 0 SHALL be dropped (we_*_o low), including MUL/LSU handshake completion.
REQ-008 LSU results SHALL enter a FIFO when lsu_valid_i && lsu_ready_o; lsu_ready_o = !full, combinational from FIFO state.
REQ-009 Port B candidates are FIFO head and mul_valid_i; a round-robin SHALL grant one per cycle, last-grant bit toggling only on a grant with both requesting; after reset MUL has priority.
REQ-010 Granted candidate SHALL appear on port B registered in cycle N+1; FIFO pops, or mul_ready_o asserts, in grant cycle N.
REQ-011 mul_ready_o SHALL be combinational, high only in the cycle MUL is granted; MUL holds data until then.
REQ-012 If the port B winner's address equals alu_waddr_i with alu_we_i high and address nonzero, B SHALL be deferred (no grant, no pop, no ready), collision_o registered high next cycle.
REQ-013 FIFO push and pop in the same cycle SHALL be allowed at any occupancy below full; an empty-FIFO push SHALL NOT be granted in the same cycle (one-cycle minimum residency).
REQ-014 FIFO pointers SHALL wrap modulo LSU_FIFO_DEPTH; occupancy counter width clog2(DEPTH+1).
REQ-015 Port A and port B SHALL never drive the same nonzero address in the same cycle.

Reset
REQ-016 On rst_n low: all we_*_o, collision_o, mul_ready_o low; waddr/wdata outputs zero; FIFO empty (lsu_ready_o high); busy_o zero; round-robin pointer to MUL.
REQ-017 Reset mid-operation SHALL discard FIFO contents and pending reservations without emitting writes.

Configuration
REQ-018 Macro RISCV_WB_SCOREBOARD_EN defined: issue_i sets busy_o[issue_waddr_i] next cycle; a port B write clears its bit in the cycle it is driven; same-cycle set and clear of one address SHALL leave it set; bit 0 never set.
REQ-019 Macro undefined: busy_o SHALL be constant zero, issue_* ignored, no scoreboard flops synthesized.

Structure
REQ-020 Shared package riscv_wb_pkg SHALL hold the wb_req_t struct (waddr, wdata) and the default widths/depth constants.
REQ-021 The LSU buffer SHALL be sub-module riscv_wb_fifo (parameterised depth, valid/ready push, pop strobe).

Verification
REQ-022 ALU we=1, addr 5, data 0xDEADBEEF in cycle 0 -> we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF in cycle 1.
REQ-023 MUL valid addr 7 plus LSU pushes addr 9 and 10 -> B writes in order 7, 9, 10; third LSU push held off with lsu_ready_o=0 while full.
REQ-024 MUL and FIFO both requesting for 4 cycles -> grants alternate MUL, LSU, MUL, LSU.
REQ-025 ALU addr 12 and MUL addr 12 same cycle -> port A writes 12, collision_o=1, MUL written on port B one cycle later.
REQ-026 With RISCV_WB_SCOREBOARD_EN: issue addr 3 -> busy_o[3]=1 next cycle; MUL result addr 3 -> cleared when we_b_o asserts; issue to addr 0 -> busy_o stays 0.
REQ-027 rst_n asserted with FIFO holding 2 entries -> no port B write after release; lsu_ready_o=1, busy_o=0.
